colision_lane_monitor: RTL and testbench
========================================

# colision_lane_monitor

Parametrised, registered successor to the 8:1 collision bit multiplexer in the JUEGO/COLISION path. Selects the overlap bit of the lane the player occupies, with code 0 as the safe lane. Adds a per-lane mask, a consecutive-sample filter and a sticky hit flag that records the lane it came from. Sits between the per-lane sprite-overlap comparators and the game-control FSM, which reads the hit and clears it.

## Interface
Parameters:
- LANES, 8, number of selector codes (code 0 = safe lane, codes 1..LANES-1 = real lanes)
- SEL_WIDTH, 3, selector width; must satisfy 2^SEL_WIDTH >= LANES
- FILTER, 2, consecutive qualifying samples required to declare a hit (range 1..15)

Ports:
- ColLane_CLOCK_50  in  1  system clock; the block uses only this clock
- ColLane_RESET_InHigh  in  1  reset, synchronous, active-high
- ColLane_Enable_In  in  1  sample strobe (game tick); the filter advances only on cycles where this is high
- ColLane_Select_Bus_In  in  SEL_WIDTH  lane occupied by the player
- ColLane_Lanes_Bus_In  in  LANES  bit i = overlap in lane i; bit 0 is ignored
- ColLane_Mask_Bus_In  in  LANES  bit i = 1 enables detection in lane i
- ColLane_Clear_In  in  1  acknowledge; clears the sticky hit
- ColLane_Raw_Out  out  1  registered selected overlap bit
- ColLane_Hit_Out  out  1  sticky collision flag
- ColLane_HitLane_Bus_Out  out  SEL_WIDTH  lane code captured when the hit is declared

## Operation
- Combinational select value q is high only when all of these hold:
  - sel != 0
  - sel < LANES
  - Mask[sel] = 1
  - Lanes[sel] = 1
- Raw_Out <= q on every cycle, independent of Enable_In.
- Internal state: FSM {IDLE, ARMING, HIT}, counter cnt (width ceil(log2(FILTER+1))), prev_sel register.
- On an enabled cycle in IDLE or ARMING:
  - If q = 0: cnt <= 0, state goes to IDLE.
  - If q = 1 and sel != prev_sel: cnt restarts at 1.
  - If q = 1 and sel = prev_sel: cnt <= cnt+1, saturating.
  - When the new cnt reaches FILTER: state goes to HIT, Hit_Out <= 1, HitLane <= sel, cnt <= 0.
  - Otherwise state goes to ARMING.
  - prev_sel <= sel on every enabled cycle.
- Cycles with Enable_In low: cnt, state and prev_sel hold. Gaps in enable therefore do not break consecutiveness.
- HIT: cnt, HitLane and prev_sel are frozen, and further overlaps are ignored. Only Clear_In or reset leaves HIT.
- Clear_In high in any state: next state IDLE, cnt <= 0, Hit_Out <= 0. HitLane keeps its last value.
  - Clear wins over a simultaneous qualifying sample; that sample is discarded, not counted.
- FILTER = 1: a hit is declared on the first qualifying enabled sample.
- Out-of-range selects (sel >= LANES) behave exactly as sel = 0.

## Timing
- Reset (synchronous, held 1 or more cycles) sets all outputs to 0, state IDLE, cnt 0, prev_sel 0. Reset has priority over Clear_In and Enable_In. Reset mid-ARMING discards the partial count.
- Raw_Out latency is 1 cycle from inputs.
- Hit_Out and HitLane update at the clock edge that closes the FILTER-th consecutive qualifying enabled cycle, so they are visible 1 cycle after that sample.
- Clear_In takes effect at the next edge: Hit_Out is low 1 cycle after Clear_In is sampled high.
- No combinational path from any input to any output.

## Structure
- Package colision_pkg holds:
  - the state typedef (IDLE, ARMING, HIT)
  - SAFE_LANE = 0
  - the default LANES, SEL_WIDTH and FILTER constants
- Sub-module lane_select_mux: parametrised LANES:1 combinational selector producing q (zero on SAFE_LANE, out of range, or masked lane).
- The top module holds the registers, counter and FSM.

## Test plan
All scenarios use LANES = 8, FILTER = 2, Mask = 8'hFF unless stated.
1. Reset priority: sel = 3, Lanes = 8'hFF, Enable = 1, reset high 3 cycles.
   - Required: all outputs 0 during reset.
   - Required: after release, Hit_Out = 1 and HitLane = 3 exactly 2 enabled samples later, visible on the following cycle.
2. Safe lane: sel = 0, Lanes = 8'hFF, Enable = 1 for 20 cycles.
   - Required: Raw_Out = 0 and Hit_Out = 0 throughout.
3. Filter: sel = 5, Lanes[5] high for 1 enabled sample, then low.
   - Required: no hit.
   - Then 2 consecutive enabled samples high → Hit_Out = 1, HitLane = 5.
   - Then an enable pattern 1,0,0,1 with overlap held high on a fresh run → hit on the second enabled sample.
4. Sticky and clear: after a hit on lane 5, set sel = 2, Lanes = 8'h04.
   - Required: Hit_Out stays 1 and HitLane stays 5.
   - Pulse Clear_In → Hit_Out = 0 next cycle; a new hit with HitLane = 2 after 2 more enabled samples.
5. Clear vs. sample and select change:
   - Clear_In coincident with the 2nd qualifying sample → no hit; 2 further samples are required.
   - sel changes 4→6 mid-run with Lanes = 8'h50 → cnt restarts; hit lands on lane 6 after 2 samples at sel = 6.
6. Mask: Mask = 8'hEF, sel = 4, Lanes = 8'h10, Enable = 1 for 10 cycles.
   - Required: Raw_Out = 0 and Hit_Out = 0.

Source files
------------

// File: rtl/colision_lane_monitor_pkg.sv
// Shared types and default sizing for the lane collision monitor.
// The FSM encoding and the safe-lane code live here so the mux and the top agree.
package colision_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    HIT    = 2'd2
  } state_t;

  localparam int SAFE_LANE     = 0;
  localparam int LANES_DEF     = 8;
  localparam int SEL_WIDTH_DEF = 3;
  localparam int FILTER_DEF    = 2;

endpackage

// File: rtl/colision_lane_monitor_lane_select_mux.sv
// LANES:1 overlap selector. The output is high only for an in-range, non-safe,
// unmasked lane whose overlap bit is set.
module lane_select_mux
  import colision_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int SEL_WIDTH = SEL_WIDTH_DEF
) (
  input  logic [SEL_WIDTH-1:0] i_sel,
  input  logic [LANES-1:0]     i_lanes,
  input  logic [LANES-1:0]     i_mask,
  output logic                 o_q
);

  logic [LANES-1:0] w_lane_hit;

  // One decoder leg per lane; codes at or beyond LANES never match any leg.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [SEL_WIDTH-1:0] CODE = SEL_WIDTH'(gi);
      if (gi == SAFE_LANE) begin : g_safe
        assign w_lane_hit[gi] = 1'b0;
      end else begin : g_real
        assign w_lane_hit[gi] = (i_sel == CODE) & i_lanes[gi] & i_mask[gi];
      end
    end
  endgenerate

  assign o_q = |w_lane_hit;

endmodule

// File: rtl/colision_lane_monitor.sv
// Registered lane collision monitor: selected overlap bit, consecutive-sample
// filter and a sticky hit flag that remembers the lane it came from.
module colision_lane_monitor
  import colision_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int SEL_WIDTH = SEL_WIDTH_DEF,
  parameter int FILTER    = FILTER_DEF
) (
  input  logic                 ColLane_CLOCK_50,
  input  logic                 ColLane_RESET_InHigh,
  input  logic                 ColLane_Enable_In,
  input  logic [SEL_WIDTH-1:0] ColLane_Select_Bus_In,
  input  logic [LANES-1:0]     ColLane_Lanes_Bus_In,
  input  logic [LANES-1:0]     ColLane_Mask_Bus_In,
  input  logic                 ColLane_Clear_In,
  output logic                 ColLane_Raw_Out,
  output logic                 ColLane_Hit_Out,
  output logic [SEL_WIDTH-1:0] ColLane_HitLane_Bus_Out
);

  localparam int CNT_W = (FILTER < 1) ? 1 : $clog2(FILTER + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] FILTER_C = CNT_W'(FILTER);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [SEL_WIDTH-1:0] r_prev_sel;
  logic                 r_raw;
  logic                 r_hit;
  logic [SEL_WIDTH-1:0] r_hit_lane;

  logic                 w_q;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [CNT_W-1:0]     w_cnt_new;

  lane_select_mux #(
    .LANES     (LANES),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_mux (
    .i_sel   (ColLane_Select_Bus_In),
    .i_lanes (ColLane_Lanes_Bus_In),
    .i_mask  (ColLane_Mask_Bus_In),
    .o_q     (w_q)
  );

  // A lane change restarts the streak; staying on the same lane extends it.
  always_comb begin
    w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    w_cnt_new = (ColLane_Select_Bus_In != r_prev_sel) ? CNT_W'(1) : w_cnt_inc;
  end

  always_ff @(posedge ColLane_CLOCK_50) begin
    if (ColLane_RESET_InHigh) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_prev_sel <= '0;
      r_raw      <= 1'b0;
      r_hit      <= 1'b0;
      r_hit_lane <= '0;
    end else begin
      r_raw <= w_q;
      if (ColLane_Clear_In) begin
        // Acknowledge discards any sample arriving on the same cycle.
        r_state <= IDLE;
        r_cnt   <= '0;
        r_hit   <= 1'b0;
      end else if (ColLane_Enable_In && (r_state != HIT)) begin
        r_prev_sel <= ColLane_Select_Bus_In;
        if (!w_q) begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end else if (w_cnt_new >= FILTER_C) begin
          r_state    <= HIT;
          r_hit      <= 1'b1;
          r_hit_lane <= ColLane_Select_Bus_In;
          r_cnt      <= '0;
        end else begin
          r_cnt   <= w_cnt_new;
          r_state <= ARMING;
        end
      end
    end
  end

  assign ColLane_Raw_Out         = r_raw;
  assign ColLane_Hit_Out         = r_hit;
  assign ColLane_HitLane_Bus_Out = r_hit_lane;

endmodule

// File: tb/tb_colision_lane_monitor.sv
// Directed scenarios followed by randomized traffic, every cycle compared
// against a streak-based reference model of the collision monitor.
module tb_colision_lane_monitor;

  localparam int LANES  = 8;
  localparam int SELW   = 3;
  localparam int FILTER = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [SELW-1:0] sel;
  logic [LANES-1:0] lanes;
  logic [LANES-1:0] mask;
  logic            clr;
  logic            raw_o;
  logic            hit_o;
  logic [SELW-1:0] lane_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state: expected outputs plus the current qualifying streak.
  logic            m_raw;
  logic            m_hit;
  logic [SELW-1:0] m_lane;
  int              run_len;
  int              run_lane;

  always #5 clk = ~clk;

  colision_lane_monitor #(
    .LANES     (LANES),
    .SEL_WIDTH (SELW),
    .FILTER    (FILTER)
  ) dut (
    .ColLane_CLOCK_50        (clk),
    .ColLane_RESET_InHigh    (rst),
    .ColLane_Enable_In       (en),
    .ColLane_Select_Bus_In   (sel),
    .ColLane_Lanes_Bus_In    (lanes),
    .ColLane_Mask_Bus_In     (mask),
    .ColLane_Clear_In        (clr),
    .ColLane_Raw_Out         (raw_o),
    .ColLane_Hit_Out         (hit_o),
    .ColLane_HitLane_Bus_Out (lane_o)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit qualifies(input logic [SELW-1:0] s, input logic [LANES-1:0] l,
                                   input logic [LANES-1:0] m);
    int idx;
    idx = int'(s);
    if (idx == 0 || idx >= LANES) return 1'b0;
    return (l[idx] && m[idx]);
  endfunction

  // Behaviour of one clock edge expressed as a run of consecutive qualifying samples.
  task automatic model_edge();
    bit q;
    q = qualifies(sel, lanes, mask);
    if (rst) begin
      m_raw = 0; m_hit = 0; m_lane = '0; run_len = 0; run_lane = 0;
    end else begin
      m_raw = q;
      if (clr) begin
        m_hit = 0;
        run_len = 0;
      end else if (en && !m_hit) begin
        if (!q) begin
          run_len  = 0;
          run_lane = int'(sel);
        end else begin
          if (run_len > 0 && run_lane == int'(sel)) run_len = run_len + 1;
          else run_len = 1;
          run_lane = int'(sel);
          if (run_len >= FILTER) begin
            m_hit   = 1;
            m_lane  = sel;
            run_len = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic c, input logic [SELW-1:0] s,
                      input logic [LANES-1:0] l, input logic [LANES-1:0] m);
    rst = r; en = e; clr = c; sel = s; lanes = l; mask = m;
    @(posedge clk);
    model_edge();
    #1;
    check("raw", 8'(raw_o), 8'(m_raw));
    check("hit", 8'(hit_o), 8'(m_hit));
    check("hit_lane", 8'(lane_o), 8'(m_lane));
  endtask

  task automatic expect_hit(input string tag, input logic h);
    check(tag, 8'(hit_o), 8'(h));
  endtask

  task automatic expect_lane(input string tag, input logic [SELW-1:0] l);
    check(tag, 8'(lane_o), 8'(l));
  endtask

  initial begin
    rst = 1; en = 0; clr = 0; sel = '0; lanes = '0; mask = '1;
    m_raw = 0; m_hit = 0; m_lane = '0; run_len = 0; run_lane = 0;

    // 1. Reset priority over an active qualifying stream.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 3'd3, 8'hFF, 8'hFF);
    expect_hit("s1_reset_hit", 1'b0);
    expect_lane("s1_reset_lane", 3'd0);
    step(0, 1, 0, 3'd3, 8'hFF, 8'hFF);
    expect_hit("s1_one_sample", 1'b0);
    step(0, 1, 0, 3'd3, 8'hFF, 8'hFF);
    expect_hit("s1_hit", 1'b1);
    expect_lane("s1_lane", 3'd3);

    // 2. Safe lane never registers.
    step(0, 0, 1, 3'd0, 8'hFF, 8'hFF);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 3'd0, 8'hFF, 8'hFF);
    expect_hit("s2_safe_hit", 1'b0);
    check("s2_safe_raw", 8'(raw_o), 8'h00);

    // 3. Filter: single sample, then two consecutive, then gapped enables.
    step(0, 1, 0, 3'd5, 8'h20, 8'hFF);
    step(0, 1, 0, 3'd5, 8'h00, 8'hFF);
    expect_hit("s3_single", 1'b0);
    step(0, 1, 0, 3'd5, 8'h20, 8'hFF);
    step(0, 1, 0, 3'd5, 8'h20, 8'hFF);
    expect_hit("s3_pair", 1'b1);
    expect_lane("s3_pair_lane", 3'd5);
    step(0, 0, 1, 3'd5, 8'h20, 8'hFF);
    step(0, 1, 0, 3'd5, 8'h20, 8'hFF);
    step(0, 0, 0, 3'd5, 8'h20, 8'hFF);
    step(0, 0, 0, 3'd5, 8'h20, 8'hFF);
    expect_hit("s3_gap_pending", 1'b0);
    step(0, 1, 0, 3'd5, 8'h20, 8'hFF);
    expect_hit("s3_gap_hit", 1'b1);
    expect_lane("s3_gap_lane", 3'd5);

    // 4. Sticky hit ignores new lanes until cleared.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 3'd2, 8'h04, 8'hFF);
    expect_hit("s4_sticky", 1'b1);
    expect_lane("s4_sticky_lane", 3'd5);
    step(0, 1, 1, 3'd2, 8'h04, 8'hFF);
    expect_hit("s4_cleared", 1'b0);
    expect_lane("s4_lane_kept", 3'd5);
    step(0, 1, 0, 3'd2, 8'h04, 8'hFF);
    step(0, 1, 0, 3'd2, 8'h04, 8'hFF);
    expect_hit("s4_rehit", 1'b1);
    expect_lane("s4_rehit_lane", 3'd2);

    // 5a. Clear coincident with the completing sample discards it.
    step(0, 0, 1, 3'd2, 8'h04, 8'hFF);
    step(0, 1, 0, 3'd2, 8'h04, 8'hFF);
    step(0, 1, 1, 3'd2, 8'h04, 8'hFF);
    expect_hit("s5_clear_wins", 1'b0);
    step(0, 1, 0, 3'd2, 8'h04, 8'hFF);
    expect_hit("s5_one_more", 1'b0);
    step(0, 1, 0, 3'd2, 8'h04, 8'hFF);
    expect_hit("s5_two_more", 1'b1);
    // 5b. Lane change mid-run restarts the count.
    step(0, 0, 1, 3'd4, 8'h50, 8'hFF);
    step(0, 1, 0, 3'd4, 8'h50, 8'hFF);
    step(0, 1, 0, 3'd6, 8'h50, 8'hFF);
    expect_hit("s5_restart", 1'b0);
    step(0, 1, 0, 3'd6, 8'h50, 8'hFF);
    expect_hit("s5_lane6_hit", 1'b1);
    expect_lane("s5_lane6", 3'd6);

    // 6. Masked lane stays silent.
    step(0, 0, 1, 3'd4, 8'h10, 8'hEF);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 3'd4, 8'h10, 8'hEF);
    expect_hit("s6_mask_hit", 1'b0);
    check("s6_mask_raw", 8'(raw_o), 8'h00);

    // Reset mid-arming discards the partial count.
    step(0, 1, 0, 3'd1, 8'h02, 8'hFF);
    step(1, 1, 0, 3'd1, 8'h02, 8'hFF);
    step(0, 1, 0, 3'd1, 8'h02, 8'hFF);
    expect_hit("rst_mid_arm", 1'b0);

    // Randomized traffic with a sticky select so streaks actually form.
    begin
      logic [SELW-1:0]  r_s;
      logic [LANES-1:0] r_l;
      logic [LANES-1:0] r_m;
      r_s = 3'd1;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 4) == 0) r_s = SELW'($urandom_range(0, 7));
        r_l = ($urandom_range(0, 2) == 0) ? LANES'($urandom) : 8'hFE;
        r_m = ($urandom_range(0, 3) == 0) ? LANES'($urandom) : 8'hFF;
        step(($urandom_range(0, 60) == 0), ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 15) == 0), r_s, r_l, r_m);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
